uart_alu_cmd: RTL and testbench

- Sits directly downstream of the UART receiver, consuming its one-cycle rx_done pulse and received byte.
- Assembles a 3-byte command (operand A, operand B, opcode) and presents it atomically to the combinational ALU.
- Captures the ALU result and hands it to the UART transmitter through a start/done handshake.
- Adds an inter-byte timeout to resynchronise after lost bytes, and flags bytes dropped while busy.

---
 rtl/uart_alu_cmd_if.sv | 30 +++
 rtl/uart_alu_cmd.sv | 156 +++++++++++++++
 tb/tb_uart_alu_cmd.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_alu_cmd_if.sv
// rtl/uart_alu_cmd_if.sv - UART/ALU/transmitter signal bundle for the command sequencer
interface uart_alu_cmd_if #(
  parameter int DATA_BITS = 8,
  parameter int OP_BITS   = 6
);
  logic                 rx_done;
  logic [DATA_BITS-1:0] rx_data;
  logic [DATA_BITS-1:0] alu_result;
  logic                 tx_done;
  logic [DATA_BITS-1:0] alu_a;
  logic [DATA_BITS-1:0] alu_b;
  logic [OP_BITS-1:0]   alu_op;
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 busy;
  logic                 frame_timeout;
  logic                 rx_overrun;

  // Sequencer side
  modport slave (
    input  rx_done, rx_data, alu_result, tx_done,
    output alu_a, alu_b, alu_op, tx_start, tx_data, busy, frame_timeout, rx_overrun
  );

  // Surrounding UART/ALU side
  modport master (
    output rx_done, rx_data, alu_result, tx_done,
    input  alu_a, alu_b, alu_op, tx_start, tx_data, busy, frame_timeout, rx_overrun
  );
endinterface

// File: rtl/uart_alu_cmd.sv
// rtl/uart_alu_cmd.sv - assembles A/B/opcode bytes into an ALU command and transmits the result
module uart_alu_cmd #(
  parameter int DATA_BITS      = 8,
  parameter int OP_BITS        = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic           clk,
  input logic           reset,
  uart_alu_cmd_if.slave bus
);

  // A zero timeout disables the inter-byte watchdog; keep a 1-bit counter so widths stay legal.
  localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam int              CNT_W      = TIMEOUT_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    S_WAIT_A,
    S_WAIT_B,
    S_WAIT_OP,
    S_EXEC,
    S_SEND,
    S_WAIT_TX
  } state_t;

  state_t               state, state_d;
  logic [DATA_BITS-1:0] a_stg, a_stg_d;
  logic [DATA_BITS-1:0] b_stg, b_stg_d;
  logic [OP_BITS-1:0]   op_stg, op_stg_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [DATA_BITS-1:0] alu_a_q, alu_a_d;
  logic [DATA_BITS-1:0] alu_b_q, alu_b_d;
  logic [OP_BITS-1:0]   alu_op_q, alu_op_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic                 timeout_q, timeout_d;
  logic                 overrun_q, overrun_d;

  // State and every output register; reset aborts any command in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_WAIT_A;
      a_stg      <= '0;
      b_stg      <= '0;
      op_stg     <= '0;
      cnt        <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state      <= state_d;
      a_stg      <= a_stg_d;
      b_stg      <= b_stg_d;
      op_stg     <= op_stg_d;
      cnt        <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      timeout_q  <= timeout_d;
      overrun_q  <= overrun_d;
    end
  end

  // Next-state and next-output decode; pulses default low, data registers hold.
  always_comb begin
    state_d    = state;
    a_stg_d    = a_stg;
    b_stg_d    = b_stg;
    op_stg_d   = op_stg;
    cnt_d      = cnt;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    timeout_d  = 1'b0;
    overrun_d  = 1'b0;

    case (state)
      S_WAIT_A: begin
        if (bus.rx_done) begin
          a_stg_d = bus.rx_data;
          cnt_d   = '0;
          state_d = S_WAIT_B;
        end
      end

      S_WAIT_B, S_WAIT_OP: begin
        if (bus.rx_done) begin
          // A byte arriving in the expiry cycle wins over the timeout.
          if (state == S_WAIT_B) begin
            b_stg_d = bus.rx_data;
            state_d = S_WAIT_OP;
          end else begin
            op_stg_d = bus.rx_data[OP_BITS-1:0];
            state_d  = S_EXEC;
          end
          cnt_d = '0;
        end else if (TIMEOUT_EN) begin
          if (cnt == CNT_LAST) begin
            timeout_d = 1'b1;
            a_stg_d   = '0;
            b_stg_d   = '0;
            cnt_d     = '0;
            state_d   = S_WAIT_A;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
      end

      S_EXEC: begin
        // Operands and opcode change together so the ALU never sees a mixed command.
        alu_a_d   = a_stg;
        alu_b_d   = b_stg;
        alu_op_d  = op_stg;
        overrun_d = bus.rx_done;
        state_d   = S_SEND;
      end

      S_SEND: begin
        tx_data_d  = bus.alu_result;
        tx_start_d = 1'b1;
        overrun_d  = bus.rx_done;
        state_d    = S_WAIT_TX;
      end

      S_WAIT_TX: begin
        overrun_d = bus.rx_done;
        if (bus.tx_done) begin
          state_d = S_WAIT_A;
        end
      end

      default: begin
        state_d = S_WAIT_A;
      end
    endcase
  end

  assign bus.busy          = (state == S_EXEC) || (state == S_SEND) || (state == S_WAIT_TX);
  assign bus.alu_a         = alu_a_q;
  assign bus.alu_b         = alu_b_q;
  assign bus.alu_op        = alu_op_q;
  assign bus.tx_data       = tx_data_q;
  assign bus.tx_start      = tx_start_q;
  assign bus.frame_timeout = timeout_q;
  assign bus.rx_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_alu_cmd.sv
// tb/tb_uart_alu_cmd.sv - directed and randomized bench for uart_alu_cmd
module tb_uart_alu_cmd;
  localparam int DB = 8;
  localparam int OB = 6;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   n_start = 0;
  int   n_to    = 0;
  int   n_ovr   = 0;

  always #5 clk = ~clk;

  uart_alu_cmd_if #(.DATA_BITS(DB), .OP_BITS(OB)) bus ();

  uart_alu_cmd #(.DATA_BITS(DB), .OP_BITS(OB), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // External ALU: ADD/SUB/AND/OR/XOR on a few opcodes, pass A otherwise.
  function automatic logic [DB-1:0] alu_ref(input logic [DB-1:0] a, input logic [DB-1:0] b,
                                            input logic [OB-1:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      default: return a;
    endcase
  endfunction

  assign bus.alu_result = alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.tx_start)      n_start++;
    if (bus.frame_timeout) n_to++;
    if (bus.rx_overrun)    n_ovr++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [DB-1:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    step();
    bus.rx_done = 1'b0;
    bus.rx_data = DB'($urandom);
  endtask

  // Sends a full command and checks the fixed EXEC/SEND latency.
  task automatic cmd_to_start(input logic [DB-1:0] a, input logic [DB-1:0] b,
                              input logic [DB-1:0] opb, input int gap);
    logic [OB-1:0] op;
    op = opb[OB-1:0];
    send(a);
    idle(gap);
    send(b);
    idle(gap);
    send(opb);
    chk("exec_busy", bus.busy, 1);
    step();
    chk("alu_a", bus.alu_a, a);
    chk("alu_b", bus.alu_b, b);
    chk("alu_op", bus.alu_op, op);
    chk("tx_start_early", bus.tx_start, 0);
    step();
    chk("tx_start", bus.tx_start, 1);
    chk("tx_data", bus.tx_data, alu_ref(a, b, op));
  endtask

  task automatic finish_tx(input int delay);
    idle(delay);
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    chk("idle_busy", bus.busy, 0);
    chk("idle_tx_start", bus.tx_start, 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_alu_a"}, bus.alu_a, 0);
    chk({tag, "_alu_b"}, bus.alu_b, 0);
    chk({tag, "_alu_op"}, bus.alu_op, 0);
    chk({tag, "_tx_start"}, bus.tx_start, 0);
    chk({tag, "_tx_data"}, bus.tx_data, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_timeout"}, bus.frame_timeout, 0);
    chk({tag, "_overrun"}, bus.rx_overrun, 0);
  endtask

  initial begin
    int snap;
    logic [DB-1:0] a, b, opb, exp_res;
    logic [OB-1:0] ops [6];
    ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h01};

    reset       = 1'b1;
    bus.rx_done = 1'b0;
    bus.rx_data = '0;
    bus.tx_done = 1'b0;
    idle(3);
    chk_zero_outputs("reset");
    reset = 1'b0;
    step();

    // Basic ADD command, tx_done ten cycles after tx_start
    cmd_to_start(8'h05, 8'h03, 8'h20, 0);
    finish_tx(9);
    chk("basic_one_start", n_start, 1);

    // Timeout after a lone A byte
    snap = n_to;
    send(8'hAA);
    idle(TO - 1);
    chk("to_not_yet", bus.frame_timeout, 0);
    step();
    chk("to_pulse", bus.frame_timeout, 1);
    step();
    chk("to_single", bus.frame_timeout, 0);
    chk("to_count", n_to, snap + 1);
    cmd_to_start(8'h01, 8'h02, 8'h20, 0);
    finish_tx(2);

    // Bytes landing exactly in the expiry cycle are accepted
    snap = n_to;
    cmd_to_start(8'h11, 8'h22, 8'h20, TO - 1);
    finish_tx(3);
    chk("boundary_no_to", n_to, snap);

    // Byte dropped while waiting for the transmitter
    cmd_to_start(8'h30, 8'h05, 8'h22, 1);
    idle(2);
    snap = n_ovr;
    send(8'h77);
    chk("ovr_pulse", bus.rx_overrun, 1);
    chk("ovr_tx_data", bus.tx_data, 8'h2B);
    chk("ovr_alu_a", bus.alu_a, 8'h30);
    step();
    chk("ovr_single", bus.rx_overrun, 0);
    finish_tx(2);
    chk("ovr_count", n_ovr, snap + 1);
    cmd_to_start(8'h09, 8'h01, 8'h20, 0);
    finish_tx(1);

    // Reset while waiting for the opcode
    send(8'h10);
    send(8'h20);
    reset = 1'b1;
    step();
    reset = 1'b0;
    snap = n_start;
    chk_zero_outputs("midreset");
    idle(5);
    chk("midreset_no_start", n_start, snap);
    cmd_to_start(8'h04, 8'h04, 8'h20, 0);
    finish_tx(0);

    // tx_done coincides with the next command's A byte: that byte is lost
    cmd_to_start(8'h02, 8'h03, 8'h20, 0);
    idle(4);
    snap = n_ovr;
    bus.tx_done = 1'b1;
    bus.rx_data = 8'h40;
    bus.rx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    bus.rx_done = 1'b0;
    chk("b2b_ovr", bus.rx_overrun, 1);
    chk("b2b_idle", bus.busy, 0);
    // Host stream continues 0x06, 0x20, 0x01: framing shifts by one byte
    cmd_to_start(8'h06, 8'h20, 8'h01, 0);
    finish_tx(0);
    chk("b2b_ovr_count", n_ovr, snap + 1);

    // Randomized commands with random gaps, opcode upper bits and stray bytes
    for (int i = 0; i < 8; i++) begin
      a       = DB'($urandom);
      b       = DB'($urandom);
      opb     = {2'($urandom), ops[$urandom_range(0, 5)]};
      exp_res = alu_ref(a, b, opb[OB-1:0]);
      cmd_to_start(a, b, opb, $urandom_range(0, 30));
      if ($urandom_range(0, 1) == 1) begin
        idle($urandom_range(0, 3));
        send(DB'($urandom));
        chk("rnd_ovr", bus.rx_overrun, 1);
        chk("rnd_tx_hold", bus.tx_data, exp_res);
      end
      finish_tx($urandom_range(0, 12));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
